// File: rtl/pow_pipe_pkg.sv
// Shared mode encodings and pipeline depth for the pow_pipe block.
package pow_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_ID   = 2'd0,
    MODE_SQ   = 2'd1,
    MODE_CUBE = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam int LATENCY = 3;

endpackage

// File: rtl/pow_pipe_abs_split.sv
// Combinational sign/magnitude split of a signed operand.
module abs_split
  import pow_pipe_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic signed [WIDTH-1:0] a,
  output logic                    sign,
  output logic        [WIDTH-1:0] mag
);

  logic [WIDTH-1:0] a_u;

  // Unsigned negation keeps -2^(WIDTH-1) as 2^(WIDTH-1) instead of wrapping.
  always_comb begin
    a_u  = a;
    sign = a[WIDTH-1];
    mag  = sign ? -a_u : a_u;
  end

endmodule

// File: rtl/pow_pipe.sv
// Three-stage signed identity/square/cube pipeline with a global stall.
module pow_pipe
  import pow_pipe_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int OW    = 3 * WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] a,
  input  logic        [1:0]       mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OW-1:0]    c,
  output logic                    err
);

  function automatic logic signed [OW-1:0] pow_result(
    input mode_e              m,
    input logic               s,
    input logic [WIDTH-1:0]   mg,
    input logic [2*WIDTH-1:0] sq
  );
    logic [OW-1:0] id_u;
    logic [OW-1:0] sq_u;
    logic [OW-1:0] cube_u;
    logic [OW-1:0] r;
    id_u   = OW'(mg);
    sq_u   = OW'(sq);
    cube_u = id_u * sq_u;
    case (m)
      MODE_ID:   r = s ? -id_u : id_u;
      MODE_SQ:   r = sq_u;
      MODE_CUBE: r = s ? -cube_u : cube_u;
      default:   r = '0;
    endcase
    return r;
  endfunction

  logic               adv;
  logic               sign_p0;
  logic [WIDTH-1:0]   mag_p0;

  logic               vld_p1_d,  vld_p1_q;
  logic               sign_p1_d, sign_p1_q;
  logic [WIDTH-1:0]   mag_p1_d,  mag_p1_q;
  mode_e              mode_p1_d, mode_p1_q;

  logic               vld_p2_d,  vld_p2_q;
  logic               sign_p2_d, sign_p2_q;
  logic [WIDTH-1:0]   mag_p2_d,  mag_p2_q;
  logic [2*WIDTH-1:0] sq_p2_d,   sq_p2_q;
  mode_e              mode_p2_d, mode_p2_q;

  logic               vld_p3_d,  vld_p3_q;
  logic signed [OW-1:0] c_p3_d,  c_p3_q;
  logic               err_p3_d,  err_p3_q;

  abs_split #(.WIDTH(WIDTH)) u_abs (
    .a    (a),
    .sign (sign_p0),
    .mag  (mag_p0)
  );

  always_comb begin
    adv       = !vld_p3_q || out_ready;
    vld_p1_d  = vld_p1_q;
    sign_p1_d = sign_p1_q;
    mag_p1_d  = mag_p1_q;
    mode_p1_d = mode_p1_q;
    vld_p2_d  = vld_p2_q;
    sign_p2_d = sign_p2_q;
    mag_p2_d  = mag_p2_q;
    sq_p2_d   = sq_p2_q;
    mode_p2_d = mode_p2_q;
    vld_p3_d  = vld_p3_q;
    c_p3_d    = c_p3_q;
    err_p3_d  = err_p3_q;
    if (adv) begin
      // p0 -> p1: sign/magnitude split
      vld_p1_d  = in_valid;
      sign_p1_d = sign_p0;
      mag_p1_d  = mag_p0;
      mode_p1_d = mode_e'(mode);
      // p1 -> p2: square of the magnitude
      vld_p2_d  = vld_p1_q;
      sign_p2_d = sign_p1_q;
      mag_p2_d  = mag_p1_q;
      sq_p2_d   = (2*WIDTH)'(mag_p1_q) * (2*WIDTH)'(mag_p1_q);
      mode_p2_d = mode_p1_q;
      // p2 -> p3: signed, mode-selected result; bubbles leave c/err at zero
      vld_p3_d  = vld_p2_q;
      c_p3_d    = vld_p2_q ? pow_result(mode_p2_q, sign_p2_q, mag_p2_q, sq_p2_q) : '0;
      err_p3_d  = vld_p2_q && (mode_p2_q == MODE_RSVD);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      c_p3_q   <= '0;
      err_p3_q <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
      c_p3_q   <= c_p3_d;
      err_p3_q <= err_p3_d;
    end
  end

  always_ff @(posedge clk) begin
    sign_p1_q <= sign_p1_d;
    mag_p1_q  <= mag_p1_d;
    mode_p1_q <= mode_p1_d;
    sign_p2_q <= sign_p2_d;
    mag_p2_q  <= mag_p2_d;
    sq_p2_q   <= sq_p2_d;
    mode_p2_q <= mode_p2_d;
  end

  assign in_ready  = adv;
  assign out_valid = vld_p3_q;
  assign c         = c_p3_q;
  assign err       = err_p3_q;

endmodule

// File: doc/pow_pipe.md
POW_PIPE -- requirements
Module: pow_pipe

Interface
REQ-001 Parameter WIDTH, default 4: input operand width; signed two's complement; legal range 2..16.
REQ-002 Parameter OW, default 3*WIDTH: result width; fixed at 3*WIDTH, never overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand and mode present this cycle.
REQ-006 in_ready  output  1  block accepts an operand this cycle.
REQ-007 a  input  WIDTH  signed operand.
REQ-008 mode  input  2  operation: 0 = a, 1 = a^2, 2 = a^3, 3 = reserved.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 c  output  OW  signed result.
REQ-012 err  output  1  result came from a reserved-mode request.

Function
REQ-013 The block SHALL be a 3-stage pipeline: S1 registers sign(a), |a| (WIDTH bits unsigned) and mode; S2 registers |a|*|a| (2*WIDTH bits) plus |a|, sign and mode; S3 registers the signed, mode-selected result into c.
REQ-014 The magnitude of a = -2^(WIDTH-1) SHALL be 2^(WIDTH-1) exactly, with no wrap.
REQ-015 Results SHALL be exact: mode 0 -> a sign-extended; mode 1 -> |a|^2, always >= 0; mode 2 -> |a|^3 negated when a < 0; no overflow is possible in OW bits.
REQ-016 Mode 3 SHALL produce c = 0 with err = 1; all other modes produce err = 0.
REQ-017 Handshake: a transfer occurs on a cycle where in_valid && in_ready; an output is consumed on a cycle where out_valid && out_ready.
REQ-018 Global advance enable: adv = !out_valid || out_ready; in_ready = adv; when adv = 0, every stage, including its valid bit, holds.
REQ-019 Each stage SHALL carry a valid bit; a stage with valid = 0 is a bubble that advances under adv and never raises out_valid.
REQ-020 Latency SHALL be exactly 3 cycles from accept to out_valid when out_ready stays 1; throughput is 1 result per cycle.
REQ-021 c and err SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-022 Ordering SHALL be preserved; no result is dropped or duplicated under any out_ready pattern.
REQ-023 Simultaneous accept and consume in one cycle SHALL be legal and lossless.

Reset
REQ-024 While rst = 1, all stage valid bits, out_valid, err and c SHALL be 0 asynchronously; in_ready is 1.
REQ-025 Reset mid-operation SHALL discard all in-flight operands; the first accept after rst deasserts yields out_valid exactly 3 cycles later.

Structure
REQ-026 Package pow_pipe_pkg SHALL hold the mode encodings (MODE_ID, MODE_SQ, MODE_CUBE, MODE_RSVD) and the constant LATENCY = 3.
REQ-027 One sub-module, abs_split (parameter WIDTH), SHALL be combinational: input signed a; outputs sign and WIDTH-bit magnitude. It is instantiated in S1.

Verification (WIDTH = 4)
REQ-028 a = 2, mode 2, out_ready = 1 -> c = 8, err = 0, exactly 3 cycles after accept.
REQ-029 a = -2 mode 2; a = -8 mode 2; a = -8 mode 1; a = 7 mode 0, on back-to-back cycles -> c = -8, -512, 64, 7 on 4 consecutive cycles.
REQ-030 Stream a = 1, 2, 3 in mode 2 with out_ready held 0 for 5 cycles, then 1 -> in_ready = 0 while stalled; c = 1 held stable; then c = 8, 27 in order; no loss.
REQ-031 a = 5, mode 3 -> c = 0, err = 1 after 3 cycles; the next op (a = 3, mode 1) gives c = 9, err = 0.
REQ-032 rst asserted for 1 cycle with 2 ops in flight -> out_valid = 0 immediately; no stale result afterwards; a new op a = -1, mode 2 gives c = -1 after 3 cycles.
REQ-033 Random in_valid/out_ready sequences (10k ops, all modes, all a) checked against a reference model -> zero mismatches, order preserved.
